// File: rtl/keypad_num_entry.sv
// 4x4 active-low keypad scanner with frame debounce and three-distinct-digit entry.
// Emits a committed guess on '#' once three digits are typed; '*' clears the entry.
module keypad_num_entry #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] iRow,
  output logic [3:0] oCol,
  output logic [3:0] oNum1,
  output logic [3:0] oNum2,
  output logic [3:0] oNum3,
  output logic       oNumRdy,
  output logic [3:0] oEnt1,
  output logic [3:0] oEnt2,
  output logic [3:0] oEnt3,
  output logic [1:0] oEntCnt
);

  localparam int unsigned DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = 8;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_MAX    = CW'(DEBOUNCE);
  localparam logic [3:0]    KEY_STAR   = 4'd10;
  localparam logic [3:0]    KEY_HASH   = 4'd11;

  typedef enum logic [1:0] {F_NONE, F_KEY, F_MULTI} frame_kind_e;
  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_e;

  // Hit index r*4+c to key value: 0..9 digits, 10 '*', 11 '#', 12..15 letters A..D.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    key_map = 4'd15;
    case (idx)
      4'd0:  key_map = 4'd1;
      4'd1:  key_map = 4'd2;
      4'd2:  key_map = 4'd3;
      4'd3:  key_map = 4'd12;
      4'd4:  key_map = 4'd4;
      4'd5:  key_map = 4'd5;
      4'd6:  key_map = 4'd6;
      4'd7:  key_map = 4'd13;
      4'd8:  key_map = 4'd7;
      4'd9:  key_map = 4'd8;
      4'd10: key_map = 4'd9;
      4'd11: key_map = 4'd14;
      4'd12: key_map = KEY_STAR;
      4'd13: key_map = 4'd0;
      4'd14: key_map = KEY_HASH;
      default: key_map = 4'd15;
    endcase
  endfunction

  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [15:0]   hit_acc, cur_hits, frame_hits;
  logic          sample, frame_done;
  logic [4:0]    n_hits;
  logic [3:0]    hit_idx;
  frame_kind_e   frame_kind;
  logic [5:0]    frame_val, prev_val;
  logic [CW-1:0] deb_cnt, deb_cnt_n;
  logic          deb_hit;
  logic          armed;
  logic          key_evt;
  logic [3:0]    key_val;

  state_e        state, state_n;
  logic [3:0]    ent1_n, ent2_n, ent3_n;
  logic [1:0]    cnt_n;
  logic [3:0]    num1_n, num2_n, num3_n;
  logic          rdy_n;
  logic          is_digit, dup;

  assign sample     = (dwell == DWELL_LAST);
  assign frame_done = sample && (col_idx == 2'd3);

  // Synchronizer, column dwell/rotation and per-frame hit accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1  <= 4'hF;
      row_s2  <= 4'hF;
      dwell   <= '0;
      col_idx <= 2'd0;
      oCol    <= 4'b1110;
      hit_acc <= '0;
    end else begin
      row_s1 <= iRow;
      row_s2 <= row_s1;
      if (sample) begin
        dwell   <= '0;
        col_idx <= col_idx + 2'd1;
        oCol    <= {oCol[2:0], oCol[3]};
        hit_acc <= frame_done ? 16'h0 : frame_hits;
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  // Classify the frame (including the column being sampled now) and advance the debounce count.
  always_comb begin
    cur_hits = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        cur_hits[r*4+c] = (col_idx == 2'(c)) && !row_s2[r];
      end
    end
    frame_hits = hit_acc | cur_hits;
    n_hits     = '0;
    hit_idx    = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_hits[i]) begin
        n_hits  = n_hits + 5'd1;
        hit_idx = 4'(i);
      end
    end
    if (n_hits == 5'd0)      frame_kind = F_NONE;
    else if (n_hits == 5'd1) frame_kind = F_KEY;
    else                     frame_kind = F_MULTI;
    frame_val = {frame_kind, (frame_kind == F_KEY) ? hit_idx : 4'd0};
    if (frame_val != prev_val)  deb_cnt_n = CW'(1);
    else if (deb_cnt == DEB_MAX) deb_cnt_n = deb_cnt;
    else                         deb_cnt_n = deb_cnt + CW'(1);
    deb_hit = (deb_cnt_n == DEB_MAX);
  end

  // A debounced release arms; a debounced key or multi-press disarms, the key also emitting once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_val <= '0;
      deb_cnt  <= '0;
      armed    <= 1'b0;
      key_evt  <= 1'b0;
      key_val  <= 4'd0;
    end else begin
      key_evt <= 1'b0;
      if (frame_done) begin
        prev_val <= frame_val;
        deb_cnt  <= deb_cnt_n;
        if (deb_hit) begin
          case (frame_kind)
            F_NONE: armed <= 1'b1;
            F_KEY: begin
              if (armed) begin
                key_evt <= 1'b1;
                key_val <= key_map(hit_idx);
              end
              armed <= 1'b0;
            end
            default: armed <= 1'b0;
          endcase
        end
      end
    end
  end

  // Entry FSM next state and outputs.
  always_comb begin
    state_n  = state;
    ent1_n   = oEnt1;
    ent2_n   = oEnt2;
    ent3_n   = oEnt3;
    cnt_n    = oEntCnt;
    num1_n   = oNum1;
    num2_n   = oNum2;
    num3_n   = oNum3;
    rdy_n    = 1'b0;
    is_digit = (key_val <= 4'd9);
    dup      = ((oEntCnt >= 2'd1) && (oEnt1 == key_val)) ||
               ((oEntCnt >= 2'd2) && (oEnt2 == key_val));
    if (key_evt) begin
      if (is_digit) begin
        if ((state != S_FULL) && !dup) begin
          case (oEntCnt)
            2'd0:    ent1_n = key_val;
            2'd1:    ent2_n = key_val;
            default: ent3_n = key_val;
          endcase
          cnt_n   = oEntCnt + 2'd1;
          state_n = (oEntCnt == 2'd2) ? S_FULL : S_PARTIAL;
        end
      end else if (key_val == KEY_STAR) begin
        ent1_n  = 4'd0;
        ent2_n  = 4'd0;
        ent3_n  = 4'd0;
        cnt_n   = 2'd0;
        state_n = S_EMPTY;
      end else if ((key_val == KEY_HASH) && (state == S_FULL)) begin
        num1_n  = oEnt1;
        num2_n  = oEnt2;
        num3_n  = oEnt3;
        rdy_n   = 1'b1;
        ent1_n  = 4'd0;
        ent2_n  = 4'd0;
        ent3_n  = 4'd0;
        cnt_n   = 2'd0;
        state_n = S_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_EMPTY;
      oEnt1   <= 4'd0;
      oEnt2   <= 4'd0;
      oEnt3   <= 4'd0;
      oEntCnt <= 2'd0;
      oNum1   <= 4'd0;
      oNum2   <= 4'd0;
      oNum3   <= 4'd0;
      oNumRdy <= 1'b0;
    end else begin
      state   <= state_n;
      oEnt1   <= ent1_n;
      oEnt2   <= ent2_n;
      oEnt3   <= ent3_n;
      oEntCnt <= cnt_n;
      oNum1   <= num1_n;
      oNum2   <= num2_n;
      oNum3   <= num3_n;
      oNumRdy <= rdy_n;
    end
  end

endmodule

// File: tb/tb_keypad_num_entry.sv
// Bench for keypad_num_entry: directed key table, multi-key/reset sequences and
// random key traffic checked against a digit-entry model.
module tb_keypad_num_entry;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEBOUNCE = 2;
  localparam int FRAME = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] iRow;
  logic [3:0] oCol;
  logic [3:0] oNum1, oNum2, oNum3;
  logic       oNumRdy;
  logic [3:0] oEnt1, oEnt2, oEnt3;
  logic [1:0] oEntCnt;
  logic [15:0] pressed = 16'h0;

  int n_pass = 0;
  int n_total = 0;

  keypad_num_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .reset(reset), .iRow(iRow), .oCol(oCol),
    .oNum1(oNum1), .oNum2(oNum2), .oNum3(oNum3), .oNumRdy(oNumRdy),
    .oEnt1(oEnt1), .oEnt2(oEnt2), .oEnt3(oEnt3), .oEntCnt(oEntCnt)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    iRow = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !oCol[c]) iRow[r] = 1'b0;
  end

  // Pulse monitor: count strobes, width violations and entries not cleared alongside.
  int   mon_pulses = 0;
  int   mon_wide = 0;
  int   mon_bad = 0;
  logic prev_rdy = 1'b0;
  always @(negedge clk) begin
    if (oNumRdy) begin
      mon_pulses++;
      if (prev_rdy) mon_wide++;
      if (oEntCnt != 2'd0 || {oEnt1, oEnt2, oEnt3} != 12'h0) mon_bad++;
    end
    prev_rdy = oNumRdy;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int key_idx(input byte ch);
    case (ch)
      "1": return 0;  "2": return 1;  "3": return 2;  "A": return 3;
      "4": return 4;  "5": return 5;  "6": return 6;  "B": return 7;
      "7": return 8;  "8": return 9;  "9": return 10; "C": return 11;
      "*": return 12; "0": return 13; "#": return 14; default: return 15;
    endcase
  endfunction

  function automatic logic [15:0] key_mask(input byte ch);
    return 16'(1) << key_idx(ch);
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hit_key(input byte ch, input int frames);
    pressed = key_mask(ch);
    wait_cycles(frames * FRAME);
  endtask

  task automatic release_all(input int frames);
    pressed = 16'h0;
    wait_cycles(frames * FRAME);
  endtask

  task automatic check_state(input string tag, input int cnt, input logic [11:0] ent,
                             input int pulses, input logic [11:0] num);
    check({tag, "_cnt"}, int'(oEntCnt), cnt);
    check({tag, "_ent"}, int'({oEnt1, oEnt2, oEnt3}), int'(ent));
    check({tag, "_pulses"}, mon_pulses, pulses);
    check({tag, "_num"}, int'({oNum1, oNum2, oNum3}), int'(num));
  endtask

  // Digit-entry model: three distinct digits, '*' clears, '#' commits only when full.
  int          m_ent[3];
  int          m_cnt;
  logic [11:0] m_num;
  int          exp_pulses;

  task automatic model_key(input byte ch);
    int d;
    bit dp;
    if (ch >= "0" && ch <= "9") begin
      d  = int'(ch) - int'("0");
      dp = 1'b0;
      for (int i = 0; i < m_cnt; i++) if (m_ent[i] == d) dp = 1'b1;
      if (m_cnt < 3 && !dp) begin
        m_ent[m_cnt] = d;
        m_cnt++;
      end
    end else if (ch == "*") begin
      m_ent = '{0, 0, 0};
      m_cnt = 0;
    end else if (ch == "#" && m_cnt == 3) begin
      m_num = {4'(m_ent[0]), 4'(m_ent[1]), 4'(m_ent[2])};
      exp_pulses++;
      m_ent = '{0, 0, 0};
      m_cnt = 0;
    end
  endtask

  function automatic logic [11:0] model_ent();
    return {4'(m_ent[0]), 4'(m_ent[1]), 4'(m_ent[2])};
  endfunction

  typedef struct {
    byte         key;
    int          hold;
    int          cnt;
    logic [11:0] ent;
    int          pulses;
    logic [11:0] num;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [3:0]  exp_col;
    logic [15:0] mm;
    byte         kc;
    string       ks;
    int          i1, i2, sel;

    vecs.push_back('{"1", 4,  1, 12'h100, 0, 12'h000});
    vecs.push_back('{"2", 4,  2, 12'h120, 0, 12'h000});
    vecs.push_back('{"3", 4,  3, 12'h123, 0, 12'h000});
    vecs.push_back('{"#", 4,  0, 12'h000, 1, 12'h123});
    vecs.push_back('{"5", 20, 1, 12'h500, 1, 12'h123});
    vecs.push_back('{"5", 4,  1, 12'h500, 1, 12'h123});
    vecs.push_back('{"7", 4,  2, 12'h570, 1, 12'h123});
    vecs.push_back('{"9", 4,  3, 12'h579, 1, 12'h123});
    vecs.push_back('{"4", 4,  3, 12'h579, 1, 12'h123});
    vecs.push_back('{"*", 4,  0, 12'h000, 1, 12'h123});
    vecs.push_back('{"8", 4,  1, 12'h800, 1, 12'h123});
    vecs.push_back('{"6", 4,  2, 12'h860, 1, 12'h123});
    vecs.push_back('{"#", 4,  2, 12'h860, 1, 12'h123});
    vecs.push_back('{"*", 4,  0, 12'h000, 1, 12'h123});
    vecs.push_back('{"A", 4,  0, 12'h000, 1, 12'h123});
    vecs.push_back('{"#", 4,  0, 12'h000, 1, 12'h123});
    vecs.push_back('{"5", 4,  1, 12'h500, 1, 12'h123});
    vecs.push_back('{"0", 4,  2, 12'h500, 1, 12'h123});
    vecs.push_back('{"0", 4,  2, 12'h500, 1, 12'h123});
    vecs.push_back('{"3", 4,  3, 12'h503, 1, 12'h123});
    vecs.push_back('{"#", 4,  0, 12'h000, 2, 12'h503});

    // Reset state.
    reset = 1'b1;
    wait_cycles(3);
    check("rst_col", int'(oCol), 'hE);
    check("rst_rdy", int'(oNumRdy), 0);
    check_state("rst", 0, 12'h000, 0, 12'h000);
    reset = 1'b0;

    // Idle scan: each column held SCAN_DIV clocks, in order 0..3.
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("idle_col", int'(oCol), int'(exp_col));
    end
    @(negedge clk);
    release_all(4);
    check_state("idle", 0, 12'h000, 0, 12'h000);

    // Directed key table.
    foreach (vecs[i]) begin
      hit_key(vecs[i].key, vecs[i].hold);
      check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ent, vecs[i].pulses, vecs[i].num);
      release_all(5);
    end

    // Two keys together, then one released while the other stays held: no event.
    pressed = key_mask("1") | key_mask("2");
    wait_cycles(6 * FRAME);
    check("multi_cnt", int'(oEntCnt), 0);
    pressed = key_mask("1");
    wait_cycles(6 * FRAME);
    check("multi_one_cnt", int'(oEntCnt), 0);
    check("multi_one_ent", int'({oEnt1, oEnt2, oEnt3}), 0);
    release_all(5);
    hit_key("1", 4);
    check("after_multi_cnt", int'(oEntCnt), 1);
    check("after_multi_ent", int'({oEnt1, oEnt2, oEnt3}), 'h100);
    release_all(5);

    // Reset mid-entry with two digits.
    hit_key("8", 4);
    release_all(5);
    check("pre_rst_cnt", int'(oEntCnt), 2);
    reset = 1'b1;
    #1;
    check("mid_rst_cnt", int'(oEntCnt), 0);
    check("mid_rst_ent", int'({oEnt1, oEnt2, oEnt3}), 0);
    check("mid_rst_num", int'({oNum1, oNum2, oNum3}), 0);
    check("mid_rst_col", int'(oCol), 'hE);
    wait_cycles(3);
    reset = 1'b0;
    release_all(5);

    // Key held through reset is ignored until released and pressed again.
    pressed = key_mask("7");
    wait_cycles(2 * FRAME);
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(8 * FRAME);
    check("held_rst_cnt", int'(oEntCnt), 0);
    release_all(5);
    hit_key("7", 4);
    check("repress_cnt", int'(oEntCnt), 1);
    check("repress_ent", int'({oEnt1, oEnt2, oEnt3}), 'h700);
    release_all(5);
    hit_key("*", 4);
    release_all(5);
    check_state("pre_rand", 0, 12'h000, 2, 12'h000);

    // Random traffic against the entry model.
    m_ent = '{0, 0, 0};
    m_cnt = 0;
    m_num = 12'h000;
    exp_pulses = 2;
    ks = "0123456789#*#*ABCD";
    for (int n = 0; n < 40; n++) begin
      wait_cycles(int'($urandom_range(0, 15)));
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        i1 = int'($urandom_range(0, 15));
        i2 = (i1 + int'($urandom_range(1, 15))) % 16;
        mm = (16'(1) << i1) | (16'(1) << i2);
        pressed = mm;
        wait_cycles(int'($urandom_range(4, 6)) * FRAME);
      end else begin
        kc = ks[int'($urandom_range(0, ks.len() - 1))];
        hit_key(kc, int'($urandom_range(4, 6)));
        model_key(kc);
      end
      release_all(int'($urandom_range(5, 6)));
      check_state($sformatf("rand%0d", n), m_cnt, model_ent(), exp_pulses, m_num);
    end

    check("pulse_width", mon_wide, 0);
    check("pulse_clear", mon_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/keypad_num_entry.md
# keypad_num_entry

Scans a 4x4 active-low matrix keypad, debounces it, and assembles three distinct decimal digits into a guess for the number game. Sits directly upstream of the game display/control stage, driving its three 4-bit digits and digit-ready strobe. Also exposes the partially typed entry so the display can echo it live.

## Interface
- SCAN_DIV, 50000: clocks each column is driven before its rows are sampled (1 ms at 50 MHz); legal ≥ 4.
- DEBOUNCE, 8: consecutive identical scan frames needed to accept a press or a release; legal 1..255.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- iRow  in  4  keypad rows; active-low, pulled up externally; asynchronous to clk.
- oCol  out  4  keypad column drive; active-low one-hot.
- oNum1 / oNum2 / oNum3  out  4 each  last committed guess, first-typed digit on oNum1; BCD 0..9.
- oNumRdy  out  1  one-cycle pulse; oNum1..3 updated in the same cycle.
- oEnt1 / oEnt2 / oEnt3  out  4 each  digits typed so far; unfilled positions read 0.
- oEntCnt  out  2  number of digits typed, 0..3.

## Operation
- Key map, row r / column c: r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D. A–D are ignored everywhere.
- Row input passes through a 2-FF synchronizer before any use.
- Scanner: a dwell counter runs 0..SCAN_DIV-1 per column. Columns are driven in order 0,1,2,3,0,… (oCol 1110, 1101, 1011, 0111). Synced rows are sampled on the dwell-count-SCAN_DIV-1 cycle, and the column advances on the next edge.
- Frame: 4 column samples. Frame value is NONE (no row low), KEY(code) (exactly one row-column hit), or MULTI (two or more hits).
- Debounce:
  - A counter counts consecutive frames with equal value, saturating at DEBOUNCE. It restarts at 1 when the value changes.
  - Reaching DEBOUNCE with NONE sets `armed`.
  - Reaching DEBOUNCE with KEY while `armed` emits one internal key event and clears `armed`.
  - MULTI never emits and never arms.
  - A held key therefore emits exactly once.
- Entry FSM, states EMPTY, PARTIAL (1–2 digits), FULL (3 digits):
  - Digit, not FULL, and not equal to any already-entered digit: store in position oEntCnt+1, oEntCnt += 1.
  - Digit when FULL or a duplicate: ignored.
  - '*': clear all entry digits to 0 and set oEntCnt = 0 from any state.
  - '#' in FULL: copy oEnt1..3 to oNum1..3, pulse oNumRdy, clear entry to EMPTY.
  - '#' in EMPTY or PARTIAL: ignored.
- Reset values:
  - oCol = 1110; all counters 0; `armed` = 0, so a key held through reset is ignored until a released frame is debounced.
  - oNum1..3 = 0, oNumRdy = 0, oEnt1..3 = 0, oEntCnt = 0.

## Timing
- Sample cycle S is the last cycle of column 3's dwell. The frame value and debounce update register at edge S+1. The key event is high for the single cycle following edge S+1.
- Entry registers and oEntCnt update at the edge ending the key-event cycle. oNumRdy, oNum1..3 and the entry clear all become visible on that same edge.
- oNumRdy is high for exactly one clock. At most one key event occurs per frame, so at least 4·SCAN_DIV cycles separate two events.
- Worst-case latency from a stable row change to the event is 2 sync cycles + (DEBOUNCE+1)·4·SCAN_DIV.
- Reset asserted mid-scan or mid-entry returns all state to reset values immediately. The scan restarts at column 0 on the first edge after deassertion.

## Test plan
Bench uses SCAN_DIV=4, DEBOUNCE=2 and a keypad model that pulls a row low while its column is driven low.
- Idle after reset: oCol cycles 1110→1101→1011→0111, each held 4 clocks. No event; all outputs stay 0.
- Debounced entry: press 1, release, press 2, release, press 3, release, press #. Expect oEntCnt to step 1,2,3. Expect a single oNumRdy pulse with oNum1..3 = 1,2,3. Expect oEntCnt = 0 and oEnt1..3 = 0 in the same cycle.
- Hold and duplicates: hold 5 for 20 frames, giving one event and oEntCnt = 1. Then 5 again (rejected, count stays 1), then 7, 9, 4. Expect oEnt = 5,7,9 with 4 ignored.
- Clear and early enter: type 8, 6, then #. Expect no pulse and oEntCnt = 2. Then * gives oEntCnt = 0 and oEnt = 0,0,0.
- Multi-key and letters:
  - Press 1 and 2 together: no event.
  - Release one while the other is still held: no event; debounced NONE is required first.
  - Press A: no state change.
- Reset: key held during and after reset gives no event until released and pressed again. Reset mid-entry with 2 digits gives oEntCnt = 0 and preserves nothing.
